// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared encodings for the commit trace recorder
package trace_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_POST    = 2'd2;
    localparam logic [1:0] ST_FROZEN  = 2'd3;

    localparam logic [1:0] TRIG_MANUAL = 2'd0;
    localparam logic [1:0] TRIG_EXC    = 2'd1;
    localparam logic [1:0] TRIG_PC     = 2'd2;
    localparam logic [1:0] TRIG_EXC_PC = 2'd3;

    // Entry layout, MSB first: {pc, inst, rf_we, rd, data, exc}
    function automatic int entry_w(input int xlen);
        return 2 * xlen + 39;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace entry storage, synchronous write, asynchronous read
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 103
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buf.sv
// rtl/commit_trace_buf.sv - circular retire-trace recorder with trigger freeze and drain
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 32,
    parameter int POST_TRIG = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [XLEN-1:0]            wb_pc,
    input  logic [31:0]                wb_inst,
    input  logic                       wb_rf_we,
    input  logic [4:0]                 wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       wb_exc,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [1:0]                 trig_mode,
    input  logic [XLEN-1:0]            trig_pc,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [31:0]                rd_inst,
    output logic                       rd_rf_we,
    output logic [4:0]                 rd_rd,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_exc,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       trig_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = entry_w(XLEN);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
    logic             trig_seen_q, trig_seen_d;

    logic             trig_ev;
    logic             rec;
    logic             restart;
    logic [PTR_W-1:0] rd_ptr;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    rd_entry;

    logic [XLEN-1:0]  e_pc;
    logic [31:0]      e_inst;
    logic             e_rf_we;
    logic [4:0]       e_rd;
    logic [XLEN-1:0]  e_data;
    logic             e_exc;

    assign trig_ev = wb_valid &&
                     ((((trig_mode & TRIG_EXC) != 2'd0) && wb_exc) ||
                      (((trig_mode & TRIG_PC) != 2'd0) && (wb_pc == trig_pc)));

    // Arm in an active capture restarts it and beats stop; the restart cycle records nothing.
    assign restart = arm && ((state_q == ST_CAPTURE) || (state_q == ST_POST));
    assign rec     = wb_valid && !restart &&
                     ((state_q == ST_CAPTURE) || (state_q == ST_POST));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        trig_seen_d = trig_seen_q;

        if (rec) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_CAPTURE;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    post_cnt_d  = '0;
                    trig_seen_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (restart) begin
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    post_cnt_d  = '0;
                    trig_seen_d = 1'b0;
                end else begin
                    if (trig_ev) begin
                        trig_seen_d = 1'b1;
                        if (POST_TRIG == 0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            post_cnt_d = PTR_W'(POST_TRIG);
                            state_d    = ST_POST;
                        end
                    end
                    if (stop) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            ST_POST: begin
                if (restart) begin
                    state_d     = ST_CAPTURE;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    post_cnt_d  = '0;
                    trig_seen_d = 1'b0;
                end else begin
                    if (rec) begin
                        post_cnt_d = post_cnt_q - PTR_W'(1);
                        if (post_cnt_q == PTR_W'(1)) begin
                            state_d = ST_FROZEN;
                        end
                    end
                    if (stop) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            default: begin
                // Leaving on the final handshake avoids an idle cycle with an empty buffer.
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                end else if (rd_ready) begin
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            trig_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            trig_seen_q <= trig_seen_d;
        end
    end

    assign wr_entry = {wb_pc, wb_inst, wb_rf_we, wb_rd, wb_data, wb_exc};
    assign rd_ptr   = wr_ptr_q - count_q[PTR_W-1:0];

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (rec),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign {e_pc, e_inst, e_rf_we, e_rd, e_data, e_exc} = rd_entry;

    assign rd_valid  = (state_q == ST_FROZEN) && (count_q != '0);
    assign rd_pc     = rd_valid ? e_pc    : '0;
    assign rd_inst   = rd_valid ? e_inst  : '0;
    assign rd_rf_we  = rd_valid ? e_rf_we : 1'b0;
    assign rd_rd     = rd_valid ? e_rd    : '0;
    assign rd_data   = rd_valid ? e_data  : '0;
    assign rd_exc    = rd_valid ? e_exc   : 1'b0;
    assign state     = state_q;
    assign count     = count_q;
    assign trig_seen = trig_seen_q;

endmodule

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
Synthesizable retire-trace recorder for the pipelined RV32I core with exceptions and interrupts. It observes the WB-stage commit stream (PC, instruction, rf write, exception flag) and keeps the last DEPTH commits in a circular buffer. It freezes after a configurable trigger plus a post-trigger window. The frozen history is then drained oldest-first over a valid/ready stream for on-chip debug of pipeline and exception behaviour.

Parameters:
DEPTH, 16, number of trace entries; must be a power of 2 and at least 2
XLEN, 32, width of PC and write-back data
POST_TRIG, 4, commits captured after the trigger commit before freezing; 0 to DEPTH-1

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous and active-high (one clock; polarity and synchronicity fixed)
wb_valid  in  1  a commit retires in WB this cycle
wb_pc  in  XLEN  PC of the committing instruction
wb_inst  in  32  instruction word
wb_rf_we  in  1  register-file write enable of the commit
wb_rd  in  5  destination register
wb_data  in  XLEN  write-back data
wb_exc  in  1  commit took an exception or interrupt
arm  in  1  start capture (pulse)
stop  in  1  manual freeze (pulse)
trig_mode  in  2  0=manual only, 1=on exception, 2=on PC match, 3=exception or PC match
trig_pc  in  XLEN  PC compare value
rd_valid  out  1  drained entry available
rd_ready  in  1  consumer accepts entry
rd_pc  out  XLEN  entry PC
rd_inst  out  32  entry instruction
rd_rf_we  out  1  entry rf write enable
rd_rd  out  5  entry destination register
rd_data  out  XLEN  entry write-back data
rd_exc  out  1  entry exception flag
state  out  2  IDLE=0, CAPTURE=1, POST=2, FROZEN=3
count  out  clog2(DEPTH+1)  valid entries held
trig_seen  out  1  trigger fired since the last arm

Behaviour:
- Reset: state=IDLE, wr_ptr=0, count=0, post_cnt=0, trig_seen=0, rd_valid=0. All rd_* outputs read 0; entry storage is not reset, but outputs are gated to 0 when rd_valid=0.
- A commit is recorded only when wb_valid=1 and state is CAPTURE or POST. The write lands at wr_ptr, wr_ptr increments modulo DEPTH, and count saturates at DEPTH. The oldest entry is overwritten when the buffer is full.
- Trigger event: wb_valid AND ((mode bit0 AND wb_exc) OR (mode bit1 AND wb_pc==trig_pc)). Mode 0 never auto-triggers. wb_exc or a PC match without wb_valid is ignored.
- IDLE: on arm, go to CAPTURE next cycle with wr_ptr=0, count=0, trig_seen=0. Stop is ignored.
- CAPTURE: on a trigger event, record the trigger commit and set trig_seen=1. If POST_TRIG=0, go to FROZEN; otherwise load post_cnt=POST_TRIG and go to POST. Stop moves to FROZEN next cycle; a commit in that same cycle is still recorded.
- POST: each recorded commit decrements post_cnt. A write that takes post_cnt to 0 moves to FROZEN. Cycles with wb_valid=0 do not decrement. Further trigger events are ignored. Stop freezes immediately.
- FROZEN: no recording. rd_ptr=(wr_ptr-count) mod DEPTH.
  - rd_valid=1 when count!=0, and rd_* show the entry at rd_ptr combinationally.
  - On rd_valid AND rd_ready, count decrements and the next entry is presented the following cycle.
  - While rd_ready=0, rd_* hold stable.
  - When count reaches 0, go to IDLE. If count is already 0 on entry, go to IDLE the next cycle.
  - Arm is ignored in FROZEN.
- arm in CAPTURE or POST restarts capture: pointers and count cleared, state=CAPTURE.
- Simultaneous arm and stop: arm wins in all states except FROZEN, where both are ignored.
- rst mid-operation, including mid-drain: returns to IDLE and rd_valid=0 from the next edge.

Decomposition:
- Package trace_pkg holds: the state encoding, the trig_mode constants, and the entry packing {pc, inst, rf_we, rd, data, exc} plus its width (2*XLEN+39).
- One sub-module, trace_ram: DEPTH x entry-width storage with one synchronous write port and one asynchronous read port.

Test Plan:
1. Reset: assert rst for 2 cycles while arming -> state=0, count=0, rd_valid=0, trig_seen=0.
2. Mode 0: arm, then 20 commits with PC 0x00..0x4C step 4, then stop -> count=16; the drain yields PC 0x10..0x4C in order, then state=IDLE.
3. Mode 1, POST_TRIG=4: arm, 10 commits from PC 0x00 with wb_exc on PC 0x14 -> FROZEN right after the PC 0x24 commit; the drain yields 10 entries 0x00..0x24; rd_exc=1 only on 0x14; trig_seen=1.
4. Mode 2, trig_pc=0x100: commits interleaved with wb_valid=0 gaps during POST, and wb_exc asserted while wb_valid=0 -> gaps do not decrement post_cnt and the exc is ignored; exactly 4 commits are recorded after 0x100.
5. Backpressure: toggle rd_ready 1,0,0,1 during the drain -> rd_* stable while rd_ready=0; no entry is skipped or duplicated; count decrements only on handshake.
6. Reset mid-drain with count=7 -> next cycle state=IDLE, rd_valid=0, count=0; arm pulsed while FROZEN -> no effect.
